// File: rtl/mem_access_unit.sv
// Memory-stage load/store access controller: alignment check, one bus beat, extended load data.
// Optional MEM_ACCESS_RANGE_CHECK_EN also faults aligned addresses above RANGE_HI.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RANGE_HI = ADDR_WIDTH'(32'h0000_2FFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_byteen,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_exc,
    output logic [4:0]            resp_exccode,
    output logic [ADDR_WIDTH-1:0] resp_badvaddr
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state;
    logic        lat_write;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;

    logic        misalign;
    logic        range_fault;
    logic        fault;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign range_fault = (req_addr > RANGE_HI);
`else
    logic unused_range_hi;
    assign unused_range_hi = ^RANGE_HI;
    assign range_fault = 1'b0;
`endif

    // Decode alignment, lane enables and replicated store data of the incoming request
    always_comb begin
        misalign  = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                acc_be    = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = req_addr[0];
                acc_be    = 4'b0011 << req_addr[1:0];
                acc_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                misalign  = |req_addr[1:0];
            end
        endcase
        if (!req_write) begin
            acc_wdata = 32'd0;
        end
        fault = misalign | range_fault;
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        ld_byte = bus_rdata[8*lat_lane +: 8];
        ld_half = lat_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_size)
            2'b00:   ld_ext = lat_uns ? {24'd0, ld_byte}
                                      : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = lat_uns ? {16'd0, ld_half}
                                      : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Access FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            lat_write     <= 1'b0;
            lat_uns       <= 1'b0;
            lat_size      <= 2'b00;
            lat_lane      <= 2'b00;
            bus_valid     <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_byteen    <= 4'd0;
            bus_wdata     <= 32'd0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_exc      <= 1'b0;
            resp_exccode  <= 5'd0;
            resp_badvaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_lane  <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (fault) begin
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_exc      <= 1'b1;
                            resp_exccode  <= req_write ? 5'd5 : 5'd4;
                            resp_badvaddr <= req_addr;
                        end else begin
                            state      <= BUS;
                            bus_valid  <= 1'b1;
                            bus_we     <= req_write;
                            bus_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus_byteen <= acc_be;
                            bus_wdata  <= acc_wdata;
                        end
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        state      <= RESP;
                        bus_valid  <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_byteen <= 4'd0;
                        bus_wdata  <= 32'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= lat_write ? 32'd0 : ld_ext;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    req_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    resp_rdata    <= 32'd0;
                    resp_exc      <= 1'b0;
                    resp_exccode  <= 5'd0;
                    resp_badvaddr <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, faults,
// bus wait states and reset during a bus transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exccode;
    logic [31:0] resp_badvaddr;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .resp_exccode(resp_exccode),
        .resp_badvaddr(resp_badvaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] bad;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];
    int    nchk = 0;
    int    nerr = 0;
    int    cyc = 0;
    int    nhs = 0;
    int    ehs = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on each resp_valid
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_exc", {31'd0, resp_exc}, {31'd0, e.exc});
                    chk("resp_exccode", {27'd0, resp_exccode}, {27'd0, e.code});
                    chk("resp_badvaddr", resp_badvaddr, e.bad);
                    chk("resp_latency", cyc - e.acc, e.lat);
                end
            end else begin
                chk("resp_idle_zero",
                    resp_rdata | resp_badvaddr | {26'd0, resp_exc, resp_exccode}, 32'd0);
            end
        end
    end

    // Bus monitor: checks every cycle of a request, pops on handshake
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus_valid) begin
                if (bq.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("bus_we", {31'd0, bus_we}, {31'd0, bq[0].we});
                    chk("bus_addr", bus_addr, bq[0].addr);
                    chk("bus_byteen", {28'd0, bus_byteen}, {28'd0, bq[0].be});
                    chk("bus_wdata", bus_wdata, bq[0].wdata);
                    if (bus_ready) begin
                        void'(bq.pop_front());
                        nhs++;
                    end
                end
            end else begin
                chk("bus_idle_zero",
                    bus_addr | bus_wdata | {27'd0, bus_byteen, bus_we}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits,
                         input logic flt, input logic [3:0] be,
                         input logic [31:0] bwd, input logic [31:0] erd,
                         input logic [4:0] code);
        resp_t r;
        bus_t  b;
        wait_ready();
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        if (!flt) begin
            b.we    = w;
            b.addr  = a & 32'hFFFF_FFFC;
            b.be    = be;
            b.wdata = bwd;
            bq.push_back(b);
            ehs++;
        end
        @(posedge clk); #1;
        r.rdata = erd;
        r.exc   = flt;
        r.code  = code;
        r.bad   = flt ? a : 32'd0;
        r.acc   = cyc;
        r.lat   = flt ? 0 : waits + 1;
        rq.push_back(r);
        if (flt) begin
            req_valid = 1'b0;
        end else begin
            repeat (waits) begin
                @(posedge clk); #1;
            end
            bus_rdata = rd;
            bus_ready = 1'b1;
            @(posedge clk); #1;
            bus_ready = 1'b0;
            bus_rdata = 32'd0;
            req_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus_t b;
        int   n;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        bus_ready    = 1'b0;
        bus_rdata    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_fields", bus_addr | bus_wdata | {27'd0, bus_byteen, bus_we}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fields",
            resp_rdata | resp_badvaddr | {26'd0, resp_exc, resp_exccode}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // bus_ready with no request in flight must do nothing
        bus_ready = 1'b1;
        bus_rdata = 32'h5555_5555;
        repeat (2) @(posedge clk);
        #1;
        bus_ready = 1'b0;
        bus_rdata = 32'd0;

        //     w  sz     u  addr          wdata         rdata         W  flt be       bus_wdata     resp_rdata    code
        issue(0, 2'b10, 0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 3, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 5'd0);
        issue(0, 2'b00, 0, 32'h0000_0013, 32'h0,        32'h80FF_0102, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 5'd0);
        issue(0, 2'b00, 1, 32'h0000_0013, 32'h0,        32'h80FF_0102, 0, 0, 4'b1000, 32'h0,        32'h0000_0080, 5'd0);
        issue(1, 2'b01, 0, 32'h0000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,        5'd0);
        issue(0, 2'b10, 0, 32'h0000_0002, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        5'd4);
        issue(1, 2'b01, 0, 32'h0000_0001, 32'h1111_2222, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        5'd5);
        issue(0, 2'b01, 0, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 2, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 5'd0);
        issue(0, 2'b01, 1, 32'h0000_0000, 32'h0,        32'h8001_F00F, 0, 0, 4'b0011, 32'h0,        32'h0000_F00F, 5'd0);
        issue(1, 2'b00, 0, 32'h0000_0021, 32'h0000_00A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        5'd0);
        issue(0, 2'b11, 1, 32'h0000_0024, 32'h0,        32'h1234_5678, 1, 0, 4'b1111, 32'h0,        32'h1234_5678, 5'd0);
        issue(0, 2'b11, 0, 32'h0000_0025, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        5'd4);
        issue(0, 2'b01, 0, 32'h0000_0003, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        5'd4);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        issue(1, 2'b10, 0, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        5'd5);
`else
        issue(1, 2'b10, 0, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        5'd0);
`endif

        // Reset while the bus is stalled: transaction abandoned
        wait_ready();
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0040;
        req_wdata    = 32'd0;
        req_valid    = 1'b1;
        b.we    = 1'b0;
        b.addr  = 32'h0000_0040;
        b.be    = 4'b1111;
        b.wdata = 32'd0;
        bq.push_back(b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_bus_valid", {31'd0, bus_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        bq.delete();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Accepts normally again after the abandoned transaction
        issue(0, 2'b00, 1, 32'h0000_0041, 32'h0,        32'h0000_7700, 0, 0, 4'b0010, 32'h0,        32'h0000_0077, 5'd0);

        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_queue_drained", rq.size(), 32'd0);
        chk("bus_queue_drained", bq.size(), 32'd0);
        chk("bus_handshakes", nhs, ehs);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller for the pipelined MIPS core. Takes load/store requests from the pipeline, checks address alignment against the access size (2^N base, N = 0/1/2), and raises AdEL/AdES without touching the bus on misalignment. Aligned accesses become a single handshaked data-bus transaction with byte enables; the block then returns extended load data. It sits between the EX/MEM pipeline register and the data-memory bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- RANGE_HI, 32'h0000_2FFF, highest legal byte address; used only when range checking is compiled in

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  pipeline presents a memory request
- req_ready  output  1  high exactly when state is IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-aligned
- bus_valid  output  1  bus request
- bus_ready  input  1  bus completes the transaction this cycle
- bus_we  output  1  write enable
- bus_addr  output  ADDR_WIDTH  word address, low two bits forced to 0
- bus_byteen  output  4  byte lane enables
- bus_wdata  output  32  lane-replicated store data
- bus_rdata  input  32  read data, valid when bus_ready
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and exceptions
- resp_exc  output  1  exception occurred
- resp_exccode  output  5  4 = AdEL, 5 = AdES, else 0
- resp_badvaddr  output  ADDR_WIDTH  faulting address; 0 when no exception

## Operation
- States: IDLE, BUS, RESP.
- IDLE: on req_valid, latch all req_* fields. Misaligned (any of addr[N-1:0] set, N = 0/1/2 for byte/half/word) -> RESP with exception; else -> BUS.
- Exception code: AdES if req_write, else AdEL. badvaddr = latched req_addr.
- BUS: bus_valid = 1; bus_* outputs driven from latched fields and held stable until bus_ready. On bus_ready: capture bus_rdata, -> RESP.
- RESP: resp_valid = 1 for exactly one cycle, then -> IDLE. Consumer cannot stall the response.
- Byte enables: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
- Store lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extraction: byte lane addr[1:0], half lane addr[1], word full; extend to 32 per req_unsigned (ignored for word).
- Outputs registered; bus_* and resp_* are 0 in any state not driving them.

## Timing
- Reset values: state IDLE, req_ready 1, bus_valid 0, bus_we 0, bus_addr 0, bus_byteen 0, bus_wdata 0, resp_valid 0, resp_rdata 0, resp_exc 0, resp_exccode 0, resp_badvaddr 0.
- Misaligned request: accepted cycle T, resp_valid at T+1; no bus_valid ever.
- Aligned: accepted T, bus_valid from T+1; bus_ready at cycle B (B >= T+1) -> resp_valid at B+1. Minimum latency 2 cycles.
- bus_ready while bus_valid low is ignored.
- req_valid during BUS/RESP is ignored (req_ready low); next acceptance is earliest the cycle after resp_valid.
- Reset mid-BUS: bus_valid drops the next edge; the in-flight transaction is abandoned, no resp_valid.

## Configuration
- MEM_ACCESS_RANGE_CHECK_EN defined: aligned access whose address exceeds RANGE_HI also faults (AdEL/AdES, same timing as misalignment, no bus transaction). Alignment fault takes precedence only in that both yield the same code.
- Undefined: only alignment is checked; RANGE_HI unused.

## Test plan
- Load word addr 0x0000_0010, bus_ready after 3 wait cycles, rdata 0xDEADBEEF -> bus_byteen 1111, resp_valid once with resp_rdata 0xDEADBEEF, resp_exc 0.
- Load signed byte addr 0x13, rdata 0x80FF_0102 -> byteen 1000, resp_rdata 0xFFFF_FF80; same with req_unsigned -> 0x0000_0080.
- Store half addr 0x0000_0006, wdata 0x1234_ABCD -> bus_addr 0x4, byteen 1100, bus_wdata 0xABCD_ABCD, bus_we 1.
- Load word addr 0x0000_0002 -> resp_valid next cycle, resp_exc 1, exccode 4, badvaddr 0x2, bus_valid never high; store half addr 0x1 -> exccode 5.
- Reset asserted while bus_valid high with bus_ready held low -> bus_valid 0 and req_ready 1 after the edge, no resp_valid.
- With MEM_ACCESS_RANGE_CHECK_EN, store word addr 0x0000_3000 -> exccode 5, badvaddr 0x3000, no bus transaction; without it, normal bus write.
